// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = in1 - in2), one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             br_reg, br_next;
    logic [WIDTH-1:0] diff_reg;
    logic             b_out_reg;
    logic             a_i, b_i, d_i;
    logic             accept, last_bit;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign a_i      = a_reg[0];
    assign b_i      = b_reg[0];
    assign d_i      = a_i ^ b_i ^ br_reg;
    assign br_next  = (~a_i & b_i) | (~(a_i ^ b_i) & br_reg);
    assign last_bit = (cnt_reg == LAST);
    assign accept   = start && (state_reg != RUN);

    // Result bits land at their final position, so the completed word is
    // available combinationally on the last RUN edge.
    generate
        if (WIDTH == 1) begin : g_res_w1
            always_comb begin
                res_next    = res_reg;
                res_next[0] = d_i;
            end
        end else begin : g_res_wn
            always_comb begin
                res_next          = res_reg;
                res_next[cnt_reg] = d_i;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = accept ? RUN : IDLE;
            RUN:     state_next = last_bit ? DONE : RUN;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            br_reg    <= 1'b0;
            diff_reg  <= '0;
            b_out_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg   <= in1;
                b_reg   <= in2;
                res_reg <= '0;
                cnt_reg <= '0;
                br_reg  <= 1'b0;
            end else if (state_reg == RUN) begin
                a_reg   <= a_reg >> 1;
                b_reg   <= b_reg >> 1;
                res_reg <= res_next;
                br_reg  <= br_next;
                cnt_reg <= cnt_reg + 1'b1;
                if (last_bit) begin
                    diff_reg  <= res_next;
                    b_out_reg <= br_next;
                end
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept aside because the shift registers lose them.
    logic a_msb_reg, b_msb_reg, ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_msb_reg <= in1[WIDTH-1];
            b_msb_reg <= in2[WIDTH-1];
        end else if (state_reg == RUN && last_bit) begin
            ovf_reg <= (a_msb_reg != b_msb_reg) && (d_i != a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign diff  = diff_reg;
    assign b_out = b_out_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 instance plus a WIDTH=1 instance,
// random and directed operands checked against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         busy, done, b_out;
    logic [W-1:0] diff;
    logic         ovf;

    logic         start1 = 1'b0;
    logic [0:0]   in1_1 = '0;
    logic [0:0]   in2_1 = '0;
    logic         busy1, done1, b_out1;
    logic [0:0]   diff1;
    logic         ovf1;

    int checks = 0;
    int errors = 0;

`ifndef SERIAL_SUB_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .in1   (in1_1),
        .in2   (in2_1),
        .busy  (busy1),
        .done  (done1),
        .diff  (diff1),
        .b_out (b_out1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: modular difference, unsigned compare, signed range test.
    function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] d, output logic bo, output logic ov);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sa - sb;
        d  = a - b;
        bo = (int'(a) < int'(b));
        ov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    // Starts an operation in the current cycle and leaves the bench in the DONE cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold_start, input string name);
        int n, busy_cnt;
        logic [W-1:0] ed;
        logic eb, eo;
        ref_sub(a, b, ed, eb, eo);
        in1 = a;
        in2 = b;
        start = 1'b1;
        tick;
        busy_cnt = busy ? 1 : 0;
        n = 0;
        start = hold_start;
        while (!done && n < 4 * W) begin
            in1 = W'($urandom);
            in2 = W'($urandom);
            tick;
            n++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        checks++;
        if (n !== W) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, W);
        end
        checks++;
        if (busy_cnt !== W) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cnt, W);
        end
        checks++;
        if (diff !== ed) begin
            errors++;
            $display("FAIL %s diff: a=%h b=%h got %h expected %h", name, a, b, diff, ed);
        end
        checks++;
        if (b_out !== eb) begin
            errors++;
            $display("FAIL %s b_out: a=%h b=%h got %b expected %b", name, a, b, b_out, eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== eo) begin
            errors++;
            $display("FAIL %s ovf: a=%h b=%h got %b expected %b", name, a, b, ovf, eo);
        end
`endif
        $display("op %s: a=%h b=%h diff=%h b_out=%b ovf=%b cycles=%0d", name, a, b, diff, b_out, ovf, n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        checks++;
        if ({busy, done, b_out, ovf} !== 4'b0000) begin
            errors++;
            $display("FAIL reset flags: busy/done/b_out/ovf got %b expected 0000", {busy, done, b_out, ovf});
        end
        checks++;
        if (diff !== '0) begin
            errors++;
            $display("FAIL reset diff: got %h expected 00", diff);
        end
        $display("reset: busy=%b done=%b diff=%h b_out=%b", busy, done, diff, b_out);
    endtask

    task automatic test_directed;
        run_op(8'h05, 8'h03, 1'b0, "5-3");
        tick;
        run_op(8'h03, 8'h05, 1'b0, "3-5");
        tick;
        run_op(8'h00, 8'h01, 1'b0, "0-1");
        run_op(8'hFF, 8'hFF, 1'b0, "ff-ff_b2b");
        repeat (3) tick;
        checks++;
        if (diff !== 8'h00 || b_out !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: diff=%h b_out=%b done=%b busy=%b expected 00/0/0/0",
                     diff, b_out, done, busy);
        end
        run_op(8'h80, 8'h01, 1'b0, "80-01");
        tick;
        run_op(8'h10, 8'h01, 1'b0, "10-01");
        tick;
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            run_op(a, b, 1'b0, "rand");
            if ($urandom_range(0, 1) == 1) tick;
        end
        tick;
    endtask

    task automatic test_start_held;
        int extra;
        run_op(8'hC3, 8'h4A, 1'b1, "held");
        extra = 0;
        repeat (5) begin
            tick;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL held_no_extra: got %0d active cycles after done, expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_run;
        run_op(8'h5A, 8'h21, 1'b0, "pre_reset");
        tick;
        in1 = 8'h77;
        in2 = 8'h12;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, b_out, ovf} !== 4'b0000 || diff !== '0) begin
            errors++;
            $display("FAIL mid_run_reset: busy=%b done=%b diff=%h b_out=%b ovf=%b expected all 0",
                     busy, done, diff, b_out, ovf);
        end
        $display("mid-run reset: busy=%b done=%b diff=%h b_out=%b", busy, done, diff, b_out);
        tick;
        rst = 1'b0;
        tick;
        run_op(8'h77, 8'h12, 1'b0, "post_reset");
        tick;
    endtask

    task automatic test_width1;
        int n;
        logic a, b, ed, eb, eo;
        for (int i = 0; i < 4; i++) begin
            a  = (i >= 2);
            b  = (i % 2 == 1);
            ed = a ^ b;
            eb = (int'(a) < int'(b));
            eo = ((a ? -1 : 0) - (b ? -1 : 0)) > 0;
            in1_1  = a;
            in2_1  = b;
            start1 = 1'b1;
            tick;
            start1 = 1'b0;
            n = 0;
            while (!done1 && n < 10) begin
                tick;
                n++;
            end
            checks++;
            if (n !== 1 || diff1 !== ed || b_out1 !== eb) begin
                errors++;
                $display("FAIL w1 %0d-%0d: cycles=%0d diff=%b b_out=%b expected cycles=1 diff=%b b_out=%b",
                         a, b, n, diff1, b_out1, ed, eb);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ovf1 !== eo) begin
                errors++;
                $display("FAIL w1 ovf %0d-%0d: got %b expected %b", a, b, ovf1, eo);
            end
`endif
            $display("w1 op: a=%0d b=%0d diff=%b b_out=%b ovf=%b cycles=%0d", a, b, diff1, b_out1, eo, n);
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_held;
        test_reset_mid_run;
        test_width1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
